// File: rtl/reg_file_scoreboard_pkg.sv
// reg_file_pkg: default register-file geometry and a popcount helper for the busy scoreboard
package reg_file_pkg;
  localparam int XLEN_D = 32;
  localparam int NREGS_D = 32;
  localparam int NRD_D = 2;
  localparam int MAXREGS = 256;
  function automatic int popcount(input logic [MAXREGS-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < MAXREGS; i++) c += int'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/reg_file_scoreboard_if.sv
// reg_file_scoreboard_if: writeback/issue/flush inputs, read addresses in; read data, rbusy, busy_vec, busy_cnt out
interface reg_file_scoreboard_if
  import reg_file_pkg::*;
#(
  parameter int XLEN = XLEN_D,
  parameter int NREGS = NREGS_D,
  parameter int NRD = NRD_D,
  localparam int AW = $clog2(NREGS)
);
  logic we;
  logic [AW-1:0] wa;
  logic [XLEN-1:0] wd;
  logic iss_valid;
  logic [AW-1:0] iss_rd;
  logic flush;
  logic [NRD*AW-1:0] ra;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0] rbusy;
  logic [NREGS-1:0] busy_vec;
  logic [AW:0] busy_cnt;
  modport master (output we, wa, wd, iss_valid, iss_rd, flush, ra, input rd, rbusy, busy_vec, busy_cnt);
  modport slave (input we, wa, wd, iss_valid, iss_rd, flush, ra, output rd, rbusy, busy_vec, busy_cnt);
endinterface

// File: rtl/reg_file_scoreboard_sb.sv
// reg_scoreboard: pending-write bits; ports clk, rst, we_i/wa_i writeback, iss_valid_i/iss_rd_i issue, flush_i, busy_vec_o, busy_cnt_o
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NREGS = NREGS_D,
  localparam int AW = $clog2(NREGS)
) (
  input  logic clk,
  input  logic rst,
  input  logic we_i,
  input  logic [AW-1:0] wa_i,
  input  logic iss_valid_i,
  input  logic [AW-1:0] iss_rd_i,
  input  logic flush_i,
  output logic [NREGS-1:0] busy_vec_o,
  output logic [AW:0] busy_cnt_o
);
  logic [NREGS-1:0] busy_q, busy_d;
  always_comb begin
    busy_d = busy_q;
    if (flush_i) busy_d = '0;
    else if (we_i) busy_d[wa_i] = 1'b0;
    if (iss_valid_i && !flush_i) busy_d[iss_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk) busy_q <= rst ? '0 : busy_d;
  assign busy_vec_o = busy_q;
  assign busy_cnt_o = (AW+1)'(popcount({{(MAXREGS-NREGS){1'b0}}, busy_q}));
endmodule

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: register file with busy scoreboard; ports clk, rst, bus (slave: writeback, issue, flush, NRD read ports)
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int XLEN = XLEN_D,
  parameter int NREGS = NREGS_D,
  parameter int NRD = NRD_D,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(NREGS)
) (
  input logic clk,
  input logic rst,
  reg_file_scoreboard_if.slave bus
);
  localparam logic BYP = BYPASS != 0;
  logic [XLEN-1:0] mem_q [NREGS];
  logic [AW-1:0] ra_w [NRD];
  logic [NREGS-1:0] busy_w;
  logic [AW:0] cnt_w;
  logic [NRD*XLEN-1:0] rd_w;
  logic [NRD-1:0] rbusy_w;
  reg_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk(clk), .rst(rst), .we_i(bus.we), .wa_i(bus.wa), .iss_valid_i(bus.iss_valid),
    .iss_rd_i(bus.iss_rd), .flush_i(bus.flush), .busy_vec_o(busy_w), .busy_cnt_o(cnt_w)
  );
  for (genvar g = 0; g < NREGS; g++) begin : g_mem
    always_ff @(posedge clk) mem_q[g] <= rst ? '0 : (g != 0 && bus.we && bus.wa == AW'(g)) ? bus.wd : mem_q[g];
  end
  for (genvar g = 0; g < NRD; g++) begin : g_ra
    assign ra_w[g] = bus.ra[g*AW +: AW];
  end
  always_comb begin
    rd_w = '0;
    rbusy_w = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_w[i*XLEN +: XLEN] = (ra_w[i] == '0) ? '0 : (BYP && bus.we && bus.wa == ra_w[i]) ? bus.wd : mem_q[ra_w[i]];
      rbusy_w[i] = busy_w[ra_w[i]] & ~(BYP && bus.we && bus.wa == ra_w[i]);
    end
  end
  assign bus.rd = rd_w;
  assign bus.rbusy = rbusy_w;
  assign bus.busy_vec = busy_w;
  assign bus.busy_cnt = cnt_w;
endmodule
